// File: rtl/bf16_exp_pkg.sv
// Shared definitions for the BF16 piecewise-linear exp unit, its table loader and benches.
package bf16_exp_pkg;

   localparam int EMIN           = -7;
   localparam int EMAX           = 6;
   localparam int N_SEG          = EMAX - EMIN;      // 13 segments per sign
   localparam int N_SGN          = 2;
   localparam int N_ENTRIES      = N_SGN * N_SEG;    // 26 table entries
   localparam int W              = 16;               // coefficient width
   localparam int IDX_W          = 4;                // holds 0..N_SEG-1
   localparam int TIMEOUT_CYCLES = 1024;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_DONE,
      ST_ERROR
   } load_state_e;

endpackage

// File: rtl/table_addr_seq.sv
// Table address sequencer: walks (sgn, idx) through (0,0)..(0,12),(1,0)..(1,12).
module table_addr_seq
   import bf16_exp_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr_i,
   input  logic             inc_i,
   output logic             sgn_o,
   output logic [IDX_W-1:0] idx_o,
   output logic             last_o
);

   logic             sgn_q, sgn_d;
   logic [IDX_W-1:0] idx_q, idx_d;

   // Next address: clear wins over increment; idx carries into the sign bank.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      sgn_d = sgn_q;
      idx_d = idx_q;
      if (clr_i) begin
         sgn_d = 1'b0;
         idx_d = '0;
      end else if (inc_i) begin
         if (idx_q == IDX_W'(N_SEG - 1)) begin
            idx_d = '0;
            sgn_d = ~sgn_q;
         end else begin
            idx_d = idx_q + 1'b1;
         end
      end
   end

   // Address register.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
      if (!rst_n) begin
         sgn_q <= 1'b0;
         idx_q <= '0;
      end else begin
         sgn_q <= sgn_d;
         idx_q <= idx_d;
      end
   end

   assign sgn_o  = sgn_q;
   assign idx_o  = idx_q;
   assign last_o = sgn_q && (idx_q == IDX_W'(N_SEG - 1));

endmodule

// File: rtl/bf16_exp_table_loader.sv
// Config-bus master that streams {base, offset} pairs into the exp unit's 2 x 13 coefficient table.
module bf16_exp_table_loader
   import bf16_exp_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_CYCLES
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2*W-1:0]   in_data,
   output logic             cfg_w_en,
   output logic             cfg_sgn,
   output logic [IDX_W-1:0] cfg_idx,
   output logic [W-1:0]     cfg_base,
   output logic [W-1:0]     cfg_offset,
   output logic             busy,
   output logic             table_valid,
   output logic             err,
   output logic [W-1:0]     checksum
);

   localparam int TMO_W = $clog2(TIMEOUT);

   load_state_e      state_q, state_d;
   logic [TMO_W-1:0] tmo_q, tmo_d;
   logic             wen_q, wen_d;
   logic             sgn_q, sgn_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [W-1:0]     base_q, base_d;
   logic [W-1:0]     off_q, off_d;
   logic [W-1:0]     sum_q, sum_d;
   logic             tv_q, tv_d;
   logic             err_q, err_d;

   logic             xfer;
   logic             seq_clr, seq_inc, seq_sgn, seq_last;
   logic [IDX_W-1:0] seq_idx;

   // start blocks a same-cycle transfer so a restart never writes a stale entry.
   assign in_ready = (state_q == ST_LOAD) && !start;
   assign xfer     = in_valid && in_ready;

   table_addr_seq u_seq (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr_i  (seq_clr),
      .inc_i  (seq_inc),
      .sgn_o  (seq_sgn),
      .idx_o  (seq_idx),
      .last_o (seq_last)
   );

   // Next-state, write-port and status logic.
   always_comb begin
      state_d = state_q;
      tmo_d   = tmo_q;
      wen_d   = 1'b0;
      sgn_d   = sgn_q;
      idx_d   = idx_q;
      base_d  = base_q;
      off_d   = off_q;
      sum_d   = sum_q;
      tv_d    = tv_q;
      err_d   = err_q;
      seq_clr = 1'b0;
      seq_inc = 1'b0;
      if (start) begin
         state_d = ST_LOAD;
         tmo_d   = '0;
         sum_d   = '0;
         tv_d    = 1'b0;
         err_d   = 1'b0;
         seq_clr = 1'b1;
      end else if (state_q == ST_LOAD) begin
         if (xfer) begin
            wen_d   = 1'b1;
            sgn_d   = seq_sgn;
            idx_d   = seq_idx;
            base_d  = in_data[2*W-1:W];
            off_d   = in_data[W-1:0];
            sum_d   = sum_q + in_data[2*W-1:W] + in_data[W-1:0];
            tmo_d   = '0;
            seq_inc = 1'b1;
            if (seq_last) begin
               state_d = ST_DONE;
               tv_d    = 1'b1;
            end
         end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
            state_d = ST_ERROR;
            err_d   = 1'b1;
         end else begin
            tmo_d = tmo_q + 1'b1;
         end
      end
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: the cfg data registers are reset too, so every output is 0 while rst_n is low.
      if (!rst_n) begin
         state_q <= ST_IDLE;
         tmo_q   <= '0;
         wen_q   <= 1'b0;
         sgn_q   <= 1'b0;
         idx_q   <= '0;
         base_q  <= '0;
         off_q   <= '0;
         sum_q   <= '0;
         tv_q    <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         tmo_q   <= tmo_d;
         wen_q   <= wen_d;
         sgn_q   <= sgn_d;
         idx_q   <= idx_d;
         base_q  <= base_d;
         off_q   <= off_d;
         sum_q   <= sum_d;
         tv_q    <= tv_d;
         err_q   <= err_d;
      end
   end

   assign cfg_w_en    = wen_q;
   assign cfg_sgn     = sgn_q;
   assign cfg_idx     = idx_q;
   assign cfg_base    = base_q;
   assign cfg_offset  = off_q;
   assign busy        = (state_q == ST_LOAD);
   assign table_valid = tv_q;
   assign err         = err_q;
   assign checksum    = sum_q;

endmodule

// File: tb/tb_bf16_exp_table_loader.sv
// Self-checking bench for bf16_exp_table_loader: directed table, corner sequences, random vs. model.
module tb_bf16_exp_table_loader;
   import bf16_exp_pkg::*;

   logic             clk;
   logic             rst_n;
   logic             start;
   logic             in_valid;
   logic             in_ready;
   logic [2*W-1:0]   in_data;
   logic             cfg_w_en;
   logic             cfg_sgn;
   logic [IDX_W-1:0] cfg_idx;
   logic [W-1:0]     cfg_base;
   logic [W-1:0]     cfg_offset;
   logic             busy;
   logic             table_valid;
   logic             err;
   logic [W-1:0]     checksum;

   int n_vec = 0;
   int n_err = 0;

   bf16_exp_table_loader dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .cfg_w_en    (cfg_w_en),
      .cfg_sgn     (cfg_sgn),
      .cfg_idx     (cfg_idx),
      .cfg_base    (cfg_base),
      .cfg_offset  (cfg_offset),
      .busy        (busy),
      .table_valid (table_valid),
      .err         (err),
      .checksum    (checksum)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // All registered outputs packed into one word for whole-state comparison.
   logic [56:0] outs;
   assign outs = {cfg_w_en, cfg_sgn, cfg_idx, cfg_base, cfg_offset, busy, table_valid, err, checksum};

   // Behavioural model: phase 0 idle, 1 loading, 2 done, 3 error.
   int          m_phase, m_cnt, m_idle;
   logic [15:0] m_sum, m_base, m_off;
   logic        m_wen, m_sgn, m_tv, m_err;
   logic [3:0]  m_idx;

   typedef struct {
      logic [31:0] data;
      logic        e_sgn;
      logic [3:0]  e_idx;
      logic        e_tv;
      logic [15:0] e_sum;
   } vec_t;
   vec_t vt[26];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
      n_vec++;
      if (act !== exp_v) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp_v, $time);
      end
   endtask

   task automatic model_reset();
      m_phase = 0; m_cnt = 0; m_idle = 0; m_sum = '0; m_base = '0; m_off = '0;
      m_wen = 1'b0; m_sgn = 1'b0; m_tv = 1'b0; m_err = 1'b0; m_idx = '0;
   endtask

   function automatic logic [56:0] model_outs();
      return {m_wen, m_sgn, m_idx, m_base, m_off, (m_phase == 1), m_tv, m_err, m_sum};
   endfunction

   // One clock cycle: drive at negedge, check in_ready, advance the model, check outputs after the edge.
   task automatic step(input logic st, input logic v, input logic [31:0] d);
      logic exp_rdy;
      @(negedge clk);
      start = st; in_valid = v; in_data = d;
      #1;
      exp_rdy = (m_phase == 1) && !st;
      check("in_ready", 64'(in_ready), 64'(exp_rdy));
      m_wen = 1'b0;
      if (st) begin
         m_phase = 1; m_cnt = 0; m_idle = 0; m_sum = '0; m_tv = 1'b0; m_err = 1'b0;
      end else if (m_phase == 1) begin
         if (v) begin
            m_wen  = 1'b1;
            m_sgn  = (m_cnt / N_SEG) != 0;
            m_idx  = 4'(m_cnt % N_SEG);
            m_base = d[31:16];
            m_off  = d[15:0];
            m_sum  = 16'((int'(m_sum) + int'(d[31:16]) + int'(d[15:0])) % 65536);
            m_cnt++;
            m_idle = 0;
            if (m_cnt == N_ENTRIES) begin m_phase = 2; m_tv = 1'b1; end
         end else begin
            m_idle++;
            if (m_idle == TIMEOUT_CYCLES) begin m_phase = 3; m_err = 1'b1; end
         end
      end
      @(posedge clk);
      #1;
      check("outs", 64'(outs), 64'(model_outs()));
   endtask

   task automatic full_load();
      step(1'b1, 1'b0, 32'h0);
      for (int k = 0; k < N_ENTRIES; k++) step(1'b0, 1'b1, vt[k].data);
   endtask

   initial begin
      logic [15:0] acc;
      rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0;
      model_reset();

      acc = '0;
      for (int k = 0; k < N_ENTRIES; k++) begin
         vt[k].data  = {16'(k), 16'(16'h0100 + k)};
         vt[k].e_sgn = (k >= 13);
         vt[k].e_idx = (k >= 13) ? 4'(k - 13) : 4'(k);
         vt[k].e_tv  = (k == N_ENTRIES - 1);
         acc         = acc + 16'(k) + 16'(16'h0100 + k);
         vt[k].e_sum = acc;
      end

      // Reset state.
      #3;
      check("reset_outs", 64'(outs), 64'h0);
      check("reset_ready", 64'(in_ready), 64'h0);
      @(negedge clk); rst_n = 1'b1;
      step(1'b0, 1'b1, 32'h1234_5678);   // IDLE ignores in_valid

      // Back-to-back full load against the directed table.
      step(1'b1, 1'b0, 32'h0);
      for (int k = 0; k < N_ENTRIES; k++) begin
         step(1'b0, 1'b1, vt[k].data);
         check("t1_wen", 64'(cfg_w_en), 64'h1);
         check("t1_sgn", 64'(cfg_sgn), 64'(vt[k].e_sgn));
         check("t1_idx", 64'(cfg_idx), 64'(vt[k].e_idx));
         check("t1_tv",  64'(table_valid), 64'(vt[k].e_tv));
         check("t1_sum", 64'(checksum), 64'(vt[k].e_sum));
      end
      check("t1_final_sum", 64'(checksum), 64'h1C8A);
      check("t1_busy", 64'(busy), 64'h0);

      // DONE ignores further traffic.
      for (int i = 0; i < 10; i++) step(1'b0, 1'b1, $urandom);
      check("done_sum", 64'(checksum), 64'h1C8A);
      check("done_wen", 64'(cfg_w_en), 64'h0);

      // in_valid toggling: writes every other cycle.
      step(1'b1, 1'b0, 32'h0);
      for (int i = 0; i < 2 * N_ENTRIES; i++)
         step(1'b0, (i % 2) == 0, vt[i / 2].data);
      check("t2_sum", 64'(checksum), 64'h1C8A);
      check("t2_err", 64'(err), 64'h0);
      check("t2_tv", 64'(table_valid), 64'h1);

      // Timeout after 5 entries, then a clean reload.
      step(1'b1, 1'b0, 32'h0);
      for (int k = 0; k < 5; k++) step(1'b0, 1'b1, vt[k].data);
      for (int i = 0; i < TIMEOUT_CYCLES - 1; i++) step(1'b0, 1'b0, 32'h0);
      check("tmo_not_yet", 64'(err), 64'h0);
      step(1'b0, 1'b0, 32'h0);
      check("tmo_err", 64'(err), 64'h1);
      check("tmo_busy", 64'(busy), 64'h0);
      check("tmo_tv", 64'(table_valid), 64'h0);
      check("tmo_ready", 64'(in_ready), 64'h0);
      step(1'b0, 1'b1, vt[0].data);      // ERROR ignores in_valid
      full_load();
      check("tmo_reload_tv", 64'(table_valid), 64'h1);
      check("tmo_reload_err", 64'(err), 64'h0);

      // Restart after entry 10.
      step(1'b1, 1'b0, 32'h0);
      for (int k = 0; k <= 10; k++) step(1'b0, 1'b1, vt[k].data);
      step(1'b1, 1'b1, 32'hDEAD_BEEF);
      check("rst10_sum", 64'(checksum), 64'h0);
      step(1'b0, 1'b1, 32'h0003_0004);
      check("rst10_wen", 64'(cfg_w_en), 64'h1);
      check("rst10_addr", 64'({cfg_sgn, cfg_idx}), 64'h0);
      check("rst10_sum2", 64'(checksum), 64'h7);

      // Asynchronous reset while a write is presented.
      step(1'b0, 1'b1, 32'h0010_0020);
      check("mid_wen", 64'(cfg_w_en), 64'h1);
      #1 rst_n = 1'b0;
      #1;
      check("mid_rst_outs", 64'(outs), 64'h0);
      check("mid_rst_ready", 64'(in_ready), 64'h0);
      model_reset();
      @(negedge clk); rst_n = 1'b1;
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, $urandom);

      // Randomized traffic against the model.
      for (int i = 0; i < 3000; i++)
         step($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, $urandom);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/bf16_exp_table_loader.md
Name: bf16_exp_table_loader

Overview:
- Config-bus master that programs the BF16 piecewise-linear exp unit's coefficient table through its write port (cfg_w_en/cfg_sgn/cfg_idx/cfg_base/cfg_offset).
- Accepts a stream of {base, offset} coefficient pairs over a valid/ready handshake.
- Sequences the pairs into the 2 x 13 table in fixed order, one entry per write.
- Reports table_valid, error on stall timeout, and a checksum for host-side confirmation.

Parameters:
- N_SEG, 13, segments per sign; exponent span Emax-Emin = 6-(-7).
- N_SGN, 2, sign banks.
- TIMEOUT_CYCLES, 1024, maximum idle cycles between accepted entries while loading before abort.
- W, 16, coefficient width (BF16 fixed-point base/offset).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse; begins (or restarts) a full table load.
- in_valid  in  1  coefficient pair valid.
- in_ready  out  1  loader can accept a pair this cycle.
- in_data  in  2*W  {base[31:16], offset[15:0]}.
- cfg_w_en  out  1  table write strobe.
- cfg_sgn  out  1  target sign bank.
- cfg_idx  out  4  target segment index 0..N_SEG-1.
- cfg_base  out  W  base to write.
- cfg_offset  out  W  offset to write.
- busy  out  1  high in LOAD.
- table_valid  out  1  all 26 entries written since last start.
- err  out  1  load aborted on timeout.
- checksum  out  W  wrapping sum of base+offset over all accepted entries.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - All outputs 0: in_ready, cfg_*, busy, table_valid, err, checksum.
  - Entry and timeout counters 0.
- States: IDLE, LOAD, DONE, ERROR.
- start in any state:
  - Next state LOAD; entry counter=0, timeout counter=0, checksum=0.
  - table_valid=0, err=0.
  - start in LOAD aborts and restarts at entry 0; the partially written table is left as is.
- in_ready = (state==LOAD) && !start. Combinational; start takes priority over a same-cycle transfer.
- Accept: a transfer occurs when in_valid && in_ready. Order is entry k = sgn*N_SEG + idx:
  - sgn 0, idx 0..12 first.
  - Then sgn 1, idx 0..12.
  - Carry from idx 12 to sgn 1 / idx 0.
- Write timing:
  - A transfer at edge t registers cfg_sgn/cfg_idx/cfg_base/cfg_offset and raises cfg_w_en for exactly the cycle after t.
  - cfg_w_en is 0 otherwise.
  - cfg_* data holds its last value when cfg_w_en=0.
  - Back-to-back transfers give back-to-back writes, throughput 1 entry/cycle.
- checksum += base + offset (mod 2^W) on each transfer, registered with the write.
- Completion: the transfer of entry 25 moves state to DONE at that same edge.
  - table_valid=1 in the cycle its write is presented and holds until the next start or reset.
  - busy=0 from that cycle.
- Timeout:
  - In LOAD, the counter increments on every cycle without a transfer and resets to 0 on a transfer.
  - When the counter reaches TIMEOUT_CYCLES-1 with no transfer, next state is ERROR, err=1 (held).
  - Table is partially written; table_valid stays 0.
  - Only start or reset leaves ERROR.
- In IDLE, DONE and ERROR, in_valid is ignored and nothing is written.
- Reset mid-load: an in-flight cfg_w_en is dropped immediately (async). The table contents in the exp unit are undefined until the next full load.
- cfg_idx never exceeds 12; cfg_sgn never exceeds 1.

Decomposition:
- Shared package bf16_exp_pkg:
  - Constants EMIN=-7, EMAX=6, N_SEG, N_SGN, N_ENTRIES=26.
  - Coefficient width W.
  - Loader state enum.
  - This package is reused by the exp unit and its bench.
- One natural sub-module, table_addr_seq: the entry/sign/index counter with clear, increment and last-entry flag.
- Timeout counter and FSM stay inline.

Test Plan:
- Reset, start, 26 back-to-back pairs with base=k, offset=0x0100+k (k=0..25):
  - 26 consecutive cfg_w_en cycles.
  - (sgn,idx) sequence (0,0)..(0,12),(1,0)..(1,12).
  - table_valid=1 on the last write cycle.
  - checksum=0x1A00+0x028A=0x1C8A.
- Same load with in_valid toggling 1/0 each cycle:
  - Writes are spaced 2 cycles apart with the same entries.
  - Final checksum 0x1C8A; no err.
- start, 5 pairs, then in_valid=0 for TIMEOUT_CYCLES cycles:
  - err=1, busy=0, table_valid=0, in_ready=0.
  - A following start clears err and a full load succeeds.
- start reasserted after entry 10:
  - in_ready=0 that cycle.
  - The next accepted pair writes (0,0); checksum restarts from 0.
- rst_n low while cfg_w_en=1 mid-load:
  - All outputs 0 immediately.
  - After release, state IDLE and in_ready=0 until start.
- In DONE, drive in_valid=1 with data for 10 cycles: no cfg_w_en, checksum unchanged.
